// File: rtl/accum_sequencer_if.sv
// Bundles the operand stream, the adder drive/return path and the result
// stream of the accumulation sequencer.
interface accum_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
);
  // Control
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;

  // Operand stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;

  // External carry-lookahead adder
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Result stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_carry;

  // Sequencer side
  modport slave (
    input  start, len, in_valid, in_data, in_sub, add_sum, add_cout, out_ready,
    output busy, in_ready, add_a, add_b, add_cin,
           out_valid, out_data, out_ovf, out_carry
  );

  // Environment side: operand source, adder and result sink
  modport master (
    output start, len, in_valid, in_data, in_sub, add_sum, add_cout, out_ready,
    input  busy, in_ready, add_a, add_b, add_cin,
           out_valid, out_data, out_ovf, out_carry
  );
endinterface

// File: rtl/accum_sequencer.sv
// Accumulation sequencer around a combinational signed adder: folds a
// stream of add/subtract operands into an accumulator and returns the
// wrapped sum with a sticky signed-overflow flag.
module accum_sequencer #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  accum_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] addA;
  logic [WIDTH-1:0] addB;
  logic             addCin;
  logic             beatAccepted;
  logic             ovfStep;

  // Subtraction is a + ~b + 1, so the most-negative operand needs no
  // special case: its inversion plus the carry-in wraps correctly.
  always_comb begin
    addA   = acc_q;
    addB   = bus.in_sub ? ~bus.in_data : bus.in_data;
    addCin = bus.in_sub;
  end

  assign bus.add_a   = addA;
  assign bus.add_b   = addB;
  assign bus.add_cin = addCin;

  // A beat counts only while accumulating; operands offered elsewhere stay with the source.
  always_comb begin
    beatAccepted = (state_q == ACCUM) && bus.in_valid;
    ovfStep      = (addA[WIDTH-1] == addB[WIDTH-1]) &&
                   (bus.add_sum[WIDTH-1] != addA[WIDTH-1]);
  end

  // State and datapath registers, cleared asynchronously so a reset abandons any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
    end
  end

  // Next-state and datapath update; everything holds unless a start or an accepted beat occurs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          carry_d = 1'b0;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? DONE : ACCUM;
        end
      end

      ACCUM: begin
        if (beatAccepted) begin
          acc_d   = bus.add_sum;
          carry_d = bus.add_cout;
          ovf_d   = ovf_q | ovfStep;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and result outputs are pure decodes of the registered state, so they stay stable while held.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_ovf   = 1'b0;
    bus.out_carry = 1'b0;
    bus.busy      = (state_q != IDLE);

    case (state_q)
      ACCUM: begin
        bus.in_ready = 1'b1;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc_q;
        bus.out_ovf   = ovf_q;
        bus.out_carry = carry_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer: models the external adder and checks
// hand-computed results for add, subtract, overflow, len=0, gaps and reset.
module tb_accum_sequencer;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;

  logic clk;
  logic rst_n;

  int vectorCount = 0;
  int missCount   = 0;

  accum_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  accum_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Combinational carry-lookahead adder stand-in.
  logic [WIDTH:0] adderFull;
  assign adderFull    = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_cin};
  assign bus.add_sum  = adderFull[WIDTH-1:0];
  assign bus.add_cout = adderFull[WIDTH];

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and tallies the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advances to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle with the given operand count.
  task automatic startRun(input logic [LEN_W-1:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    nextCycle();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  // Offers one operand (or an idle slot) for exactly one clock.
  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                               input logic sub);
    bus.in_valid = valid;
    bus.in_data  = data;
    bus.in_sub   = sub;
    nextCycle();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sub   = 1'b0;
  endtask

  // Consumes the result and confirms the return to IDLE.
  task automatic drainResult(input string tag);
    bus.out_ready = 1'b1;
    nextCycle();
    bus.out_ready = 1'b0;
    checkOutput({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, "_ovalid_after"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_busy",     {31'b0, bus.busy},      32'd0);
    checkOutput("rst_in_ready", {31'b0, bus.in_ready},  32'd0);
    checkOutput("rst_ovalid",   {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_odata",    bus.out_data,           32'd0);
    checkOutput("rst_oovf",     {31'b0, bus.out_ovf},   32'd0);
    checkOutput("rst_ocarry",   {31'b0, bus.out_carry}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    // Add stream: 5 + 7 + (-2) = 10
    startRun(8'd3);
    checkOutput("add_in_ready", {31'b0, bus.in_ready}, 32'd1);
    applyStimulus(1'b1, 32'd5, 1'b0);
    applyStimulus(1'b1, 32'd7, 1'b0);
    checkOutput("add_ovalid_early", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0);
    checkOutput("add_ovalid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("add_odata",  bus.out_data,           32'd10);
    checkOutput("add_oovf",   {31'b0, bus.out_ovf},   32'd0);
    drainResult("add");

    // Subtract mix: 100 - 30 = 70, carry out set (no borrow)
    startRun(8'd2);
    applyStimulus(1'b1, 32'd100, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd30;
    bus.in_sub   = 1'b1;
    #1;
    checkOutput("sub_add_b",   bus.add_b,             32'hFFFF_FFE1);
    checkOutput("sub_add_cin", {31'b0, bus.add_cin},  32'd1);
    checkOutput("sub_add_a",   bus.add_a,             32'd100);
    applyStimulus(1'b1, 32'd30, 1'b1);
    checkOutput("sub_odata",  bus.out_data,           32'd70);
    checkOutput("sub_ocarry", {31'b0, bus.out_carry}, 32'd1);
    checkOutput("sub_oovf",   {31'b0, bus.out_ovf},   32'd0);
    drainResult("sub");

    // Overflow: 0x7FFFFFFF + 1 wraps to 0x80000000
    startRun(8'd2);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0);
    applyStimulus(1'b1, 32'd1, 1'b0);
    checkOutput("ovf_odata",  bus.out_data,           32'h8000_0000);
    checkOutput("ovf_oovf",   {31'b0, bus.out_ovf},   32'd1);
    checkOutput("ovf_ocarry", {31'b0, bus.out_carry}, 32'd0);
    drainResult("ovf");

    // 0 - 0x80000000 overflows back to 0x80000000; new start cleared prior state
    startRun(8'd1);
    applyStimulus(1'b1, 32'h8000_0000, 1'b1);
    checkOutput("neg_odata", bus.out_data,         32'h8000_0000);
    checkOutput("neg_oovf",  {31'b0, bus.out_ovf}, 32'd1);
    drainResult("neg");

    // len = 0 with backpressure: result held stable while out_ready low
    startRun(8'd0);
    checkOutput("len0_ovalid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("len0_odata",  bus.out_data,           32'd0);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput($sformatf("hold%0d_ovalid", i), {31'b0, bus.out_valid}, 32'd1);
      checkOutput($sformatf("hold%0d_odata", i),  bus.out_data,           32'd0);
    end
    drainResult("len0");

    // Gapped input with a stray start and out_ready mid-accumulation: 1+2+3+4 = 10
    startRun(8'd4);
    applyStimulus(1'b1, 32'd1, 1'b0);
    bus.out_ready = 1'b1;
    startRun(8'd0);
    bus.out_ready = 1'b0;
    checkOutput("gap_busy",   {31'b0, bus.busy},      32'd1);
    checkOutput("gap_ovalid", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus(1'b1, 32'd2, 1'b0);
    applyStimulus(1'b0, 32'd50, 1'b0);
    applyStimulus(1'b1, 32'd3, 1'b0);
    applyStimulus(1'b0, 32'd60, 1'b0);
    checkOutput("gap_ovalid_3", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus(1'b1, 32'd4, 1'b0);
    checkOutput("gap_ovalid_4", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("gap_odata",    bus.out_data,           32'd10);
    // Operands offered in DONE are not accepted
    applyStimulus(1'b1, 32'd100, 1'b0);
    checkOutput("done_in_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("done_odata",    bus.out_data,          32'd10);
    drainResult("gap");
    checkOutput("idle_in_ready", {31'b0, bus.in_ready}, 32'd0);

    // Asynchronous reset between edges mid-accumulation
    startRun(8'd3);
    applyStimulus(1'b1, 32'd77, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy",     {31'b0, bus.busy},      32'd0);
    checkOutput("arst_in_ready", {31'b0, bus.in_ready},  32'd0);
    checkOutput("arst_ovalid",   {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    startRun(8'd1);
    applyStimulus(1'b1, 32'd9, 1'b0);
    checkOutput("post_rst_ovalid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("post_rst_odata",  bus.out_data,           32'd9);
    drainResult("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Sequential control stage wrapped around the 32-bit signed carry-lookahead adder.
- Accepts a stream of signed operands over a valid/ready handshake.
- Drives the adder's A/B/Cin inputs from an internal accumulator and the current operand, and captures the adder's Sum/Cout back into the accumulator.
- Emits the final signed sum with a sticky signed-overflow flag over an output valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width; must match the adder width.
- LEN_W, 8, width of the operand-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  LEN_W  number of operands to accumulate; sampled with start.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid & in_ready.
- in_data  input  WIDTH  signed operand.
- in_sub  input  1  1 = subtract operand, 0 = add operand; qualified by in_valid.
- add_a  output  WIDTH  to adder A.
- add_b  output  WIDTH  to adder B.
- add_cin  output  1  to adder Cin.
- add_sum  input  WIDTH  from adder Sum; combinational return path.
- add_cout  input  1  from adder Cout.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid & out_ready.
- out_data  output  WIDTH  signed accumulated result.
- out_ovf  output  1  sticky signed overflow seen during this accumulation.
- out_carry  output  1  add_cout of the last accepted operation.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; acc = 0; cnt = 0; ovf = 0; carry = 0.
  - in_ready = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_carry = 0, busy = 0.
- States: IDLE, ACCUM, DONE.
- Adder drive (combinational, every cycle):
  - add_a = acc.
  - add_b = in_sub ? ~in_data : in_data.
  - add_cin = in_sub.
  - Valid in all states; only consumed on an accepted beat.
- IDLE:
  - in_ready = 0.
  - On start: acc <= 0, ovf <= 0, carry <= 0, cnt <= len.
  - If len == 0, go to DONE; else go to ACCUM.
- ACCUM:
  - in_ready = 1.
  - On in_valid & in_ready:
    - acc <= add_sum; carry <= add_cout; cnt <= cnt - 1.
    - ovf <= ovf | ((add_a[W-1] == add_b[W-1]) & (add_sum[W-1] != add_a[W-1])).
  - If cnt == 1 on an accepted beat, go to DONE.
  - No beat accepted: hold all state.
- DONE:
  - out_valid = 1; out_data = acc; out_ovf = ovf; out_carry = carry.
  - All outputs held stable until out_ready.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
- Throughput and latency:
  - One operand per cycle.
  - out_valid asserts the cycle after the last accepted operand.
  - len == 0 asserts out_valid the cycle after start, with out_data = 0.
- Arithmetic:
  - Two's-complement wrap; no saturation.
  - Overflow detection is sticky and cleared only by start or reset.
  - Subtracting the most-negative value is handled by the inverted operand with Cin = 1.
- Boundary conditions:
  - start outside IDLE is ignored.
  - in_valid outside ACCUM is not accepted and the operand is not consumed.
  - out_ready outside DONE has no effect.
  - len = 2^LEN_W-1 accumulates exactly that many operands.
- Reset mid-operation: immediately returns to the reset values; the partial accumulation is discarded.
- add_sum and add_cout are assumed settled within the same cycle; the adder is combinational.

Test Plan:
- Add stream: start, len=3, operands +5, +7, -2 (in_sub=0), back-to-back → out_data = 10, out_ovf = 0, out_valid exactly one cycle after the third beat.
- Subtract mix: len=2, +100 add, then 30 with in_sub=1 → out_data = 70; check add_b = ~30 and add_cin = 1 on the second beat.
- Overflow: len=2, 0x7FFFFFFF add, then +1 add → out_data = 0x80000000, out_ovf = 1. Then subtract 0x80000000 from 0 (len=1) → out_data = 0x80000000, out_ovf = 1.
- len=0 plus backpressure: start with len=0 → out_data = 0 next cycle. Hold out_ready = 0 for 5 cycles → out_valid and out_data stable; state returns to IDLE one cycle after out_ready = 1.
- Gapped input: len=4 with in_valid toggling every other cycle, and start pulsed mid-ACCUM → start ignored, 4 beats accepted, correct sum, cnt never underflows.
- Async reset: assert rst_n = 0 mid-ACCUM between clock edges → busy, in_ready and out_valid go 0 immediately. After release, a new start with len=1 and operand 9 → out_data = 9.
